// File: rtl/matrix_row_accumulator_if.sv
// Read-data beat channel into the accumulator plus its group-result output channel.
// Beats are pushed with rvalid only (the source never waits); a result moves when out_valid && out_ready on the same edge.
interface matrix_row_accumulator_if #(
  parameter int LANES = 16
);
  logic                  rvalid;
  logic [LANES*32-1:0]   rdata;
  logic                  rlast;
  logic [1:0]            rresp;
  logic                  out_valid;
  logic [31:0]           out_data;
  logic                  out_ready;

  modport master (
    output rvalid, rdata, rlast, rresp, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  rvalid, rdata, rlast, rresp, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/matrix_row_accumulator.sv
// Sums every beat of LANES signed 32-bit lanes into per-group results queued in an output FIFO.
// Define MATRIX_ACC_SATURATE_EN to clamp out_data to signed 32 bits instead of wrapping.
module matrix_row_accumulator #(
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             beats_per_group,
  input  logic [31:0]             num_groups,
  matrix_row_accumulator_if.slave bus,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             beat_count,
  output logic [31:0]             group_count,
  output logic [31:0]             last_count,
  output logic [31:0]             err_count,
  output logic [31:0]             drop_count,
  output logic                    overflow,
  output logic [1:0]              dbg_state
);
  localparam int QW  = LANES / 4;
  localparam int P_W = 32 + $clog2(QW);
  localparam int S_W = P_W + 2;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q;
  logic          busy_q, done_q;
  logic [31:0]   bpg_q, ng_q, in_cnt_q, grp_in_q;

  logic                s1_valid_q, s1_close_q;
  logic [LANES*32-1:0] s1_data_q;
  logic                s2_valid_q, s2_close_q;
  logic [P_W-1:0]      s2_part_q [4];
  logic [P_W-1:0]      s2_part_d [4];
  logic                s3_valid_q, s3_close_q;
  logic [S_W-1:0]      s3_sum_q, s3_sum_d;

  logic [63:0]   acc_q, lane_ext64, result;
  logic [31:0]   result_n;
  logic [31:0]   beat_cnt_q, grp_cnt_q, last_cnt_q, err_cnt_q, drop_cnt_q;
  logic          overflow_q;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [CW-1:0] cnt_q, cnt_left;
  logic          out_valid_q;
  logic [31:0]   out_data_q;

  logic start_go, beat_ok, beat_close, last_group;
  logic push_try, push_ok, pop;

  assign start_go   = (state_q == IDLE) && start;
  assign beat_ok    = (state_q == RUN) && bus.rvalid;
  assign beat_close = (in_cnt_q == bpg_q - 32'd1);
  assign last_group = (grp_in_q == ng_q - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bpg_q    <= 32'd1;
      ng_q     <= 32'd0;
      in_cnt_q <= 32'd0;
      grp_in_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          bpg_q    <= (beats_per_group == 32'd0) ? 32'd1 : beats_per_group;
          ng_q     <= num_groups;
          in_cnt_q <= 32'd0;
          grp_in_q <= 32'd0;
          if (num_groups == 32'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: if (bus.rvalid) begin
          if (beat_close) begin
            in_cnt_q <= 32'd0;
            grp_in_q <= grp_in_q + 32'd1;
            if (last_group) state_q <= DRAIN;
          end else begin
            in_cnt_q <= in_cnt_q + 32'd1;
          end
        end
        DRAIN: if (!s1_valid_q && !s2_valid_q && !s3_valid_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The group-close flag rides with each beat so the accumulator knows when to emit.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      s1_valid_q <= 1'b0;
      s1_close_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_close_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_close_q <= 1'b0;
    end else begin
      s1_valid_q <= beat_ok;
      s1_close_q <= beat_ok && beat_close;
      s2_valid_q <= s1_valid_q;
      s2_close_q <= s1_close_q;
      s3_valid_q <= s2_valid_q;
      s3_close_q <= s2_close_q;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok) s1_data_q <= bus.rdata;
    s2_part_q <= s2_part_d;
    s3_sum_q  <= s3_sum_d;
  end

  function automatic logic [P_W-1:0] lane_ext(input logic [31:0] v);
    return {{(P_W-32){v[31]}}, v};
  endfunction

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      s2_part_d[p] = '0;
      for (int l = 0; l < QW; l++)
        s2_part_d[p] = s2_part_d[p] + lane_ext(s1_data_q[(p*QW+l)*32 +: 32]);
    end
  end

  always_comb begin
    s3_sum_d = '0;
    for (int p = 0; p < 4; p++)
      s3_sum_d = s3_sum_d + {{2{s2_part_q[p][P_W-1]}}, s2_part_q[p]};
  end

  assign lane_ext64 = {{(64-S_W){s3_sum_q[S_W-1]}}, s3_sum_q};
  assign result     = acc_q + lane_ext64;

`ifdef MATRIX_ACC_SATURATE_EN
  always_comb begin
    result_n = result[31:0];
    if (!result[63] && (|result[62:31]))      result_n = 32'h7FFF_FFFF;
    else if (result[63] && !(&result[62:31])) result_n = 32'h8000_0000;
  end
`else
  assign result_n = result[31:0];
`endif

  assign pop      = out_valid_q && bus.out_ready;
  assign push_try = s3_valid_q && s3_close_q;
  // A same-cycle pop frees the slot, so a full FIFO still takes the push.
  assign push_ok  = push_try && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
  assign cnt_left = cnt_q - CW'(pop);
  assign rd_next  = rd_ptr_q + AW'(pop);

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      acc_q      <= 64'd0;
      beat_cnt_q <= 32'd0;
      grp_cnt_q  <= 32'd0;
      last_cnt_q <= 32'd0;
      err_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      if (beat_ok)                          beat_cnt_q <= beat_cnt_q + 32'd1;
      if (beat_ok && bus.rlast)             last_cnt_q <= last_cnt_q + 32'd1;
      if (beat_ok && (bus.rresp != 2'd0))   err_cnt_q  <= err_cnt_q + 32'd1;
      if (s3_valid_q)                       acc_q      <= s3_close_q ? 64'd0 : result;
      if (push_try)                         grp_cnt_q  <= grp_cnt_q + 32'd1;
      if (push_try && !push_ok) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= result_n;
  end

  // Output register mirrors the head left after this cycle's pop; pushes show up a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q    <= rd_next;
      cnt_q       <= cnt_left + CW'(push_ok);
      out_valid_q <= (cnt_left != '0);
      if (cnt_left != '0) out_data_q <= mem_q[rd_next];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign beat_count    = beat_cnt_q;
  assign group_count   = grp_cnt_q;
  assign last_count    = last_cnt_q;
  assign err_count     = err_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign overflow      = overflow_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_matrix_row_accumulator.sv
// Directed bench for matrix_row_accumulator: expected group results are queued as beats are
// issued and a negedge monitor checks each accepted output against the queue.
`timescale 1ns/1ps
module tb_matrix_row_accumulator;
  localparam int LANES = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] beats_per_group, num_groups;
  logic        busy, done, overflow;
  logic [31:0] beat_count, group_count, last_count, err_count, drop_count;
  logic [1:0]  dbg_state;

  matrix_row_accumulator_if #(.LANES(LANES)) bus ();

  matrix_row_accumulator #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .beats_per_group(beats_per_group), .num_groups(num_groups),
    .bus(bus),
    .busy(busy), .done(done),
    .beat_count(beat_count), .group_count(group_count), .last_count(last_count),
    .err_count(err_count), .drop_count(drop_count),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_pop = 0;
  int  ov_arm_id = 0;
  int  ov_done_id = 0;
  time last_beat_t = 0;
  time ov_t = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one check per accepted result, plus the armed first-result latency check.
  always @(negedge clk) begin
    if (ov_done_id != ov_arm_id && bus.out_valid) begin
      ov_done_id = ov_arm_id;
      check("first_out_latency", ($time - ov_t - 4) / 10, 64'd5);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%0h expected no result", bus.out_data);
      end else begin
        check("out_data", {32'd0, bus.out_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [LANES*32-1:0] fill(input logic [31:0] v);
    logic [LANES*32-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*32 +: 32] = v;
    return d;
  endfunction

  function automatic logic [LANES*32-1:0] ramp();
    logic [LANES*32-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*32 +: 32] = i;
    return d;
  endfunction

  task automatic drive_beat(input logic [LANES*32-1:0] d, input logic last, input logic [1:0] resp);
    @(posedge clk); #1;
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.rlast  = last;
    bus.rresp  = resp;
    last_beat_t = $time;
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'd0;
  endtask

  task automatic do_start(input logic [31:0] bpg, input logic [31:0] ng);
    @(posedge clk); #1;
    start = 1'b1;
    beats_per_group = bpg;
    num_groups = ng;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done: got no done pulse expected one within 40 cycles", name);
    end else begin
      check({name, "_done_latency"}, ($time - last_beat_t - 4) / 10, 64'd5);
      check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: got %0d results outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] sat_exp;
    int p0;
    rst = 1'b1; start = 1'b0; beats_per_group = 32'd0; num_groups = 32'd0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0; bus.rresp = 2'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_beat_count", {32'd0, beat_count}, 64'd0);
    check("rst_drop_count", {32'd0, drop_count}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);

    // Two groups of four all-ones beats, back to back.
    do_start(32'd4, 32'd2);
    check("t1_busy_after_start", {63'd0, busy}, 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (b % 4 == 0) exp_q.push_back(32'd64);
      drive_beat(fill(32'd1), 1'b0, 2'd0);
      if (b == 3) begin
        ov_t = last_beat_t;
        ov_arm_id++;
      end
    end
    drive_idle();
    wait_done("t1");
    check("t1_beat_count", {32'd0, beat_count}, 64'd8);
    check("t1_group_count", {32'd0, group_count}, 64'd2);
    wait_drain("t1");

    // beats_per_group of zero behaves as one.
    do_start(32'd0, 32'd3);
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(32'd120);
      drive_beat(ramp(), 1'b0, 2'd0);
    end
    drive_idle();
    wait_done("t2");
    check("t2_group_count", {32'd0, group_count}, 64'd3);
    wait_drain("t2");

    // Overload: consumer stalled, 20 single-beat groups into a 16-entry FIFO.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    do_start(32'd1, 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (k < DEPTH) exp_q.push_back(32'(16 * (k + 1)));
      drive_beat(fill(32'(k + 1)), 1'b0, 2'd0);
    end
    drive_idle();
    wait_done("t3");
    check("t3_drop_count", {32'd0, drop_count}, 64'd4);
    check("t3_overflow", {63'd0, overflow}, 64'd1);
    check("t3_group_count", {32'd0, group_count}, 64'd20);
    check("t3_out_valid_held", {63'd0, bus.out_valid}, 64'd1);
    check("t3_head_held", {32'd0, bus.out_data}, 64'd16);
    p0 = n_pop;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain("t3");
    repeat (4) @(negedge clk);
    check("t3_pops", 64'(n_pop - p0), 64'd16);
    check("t3_empty_after_drain", {63'd0, bus.out_valid}, 64'd0);

    // Error response and rlast are counted; the errored beat is still summed.
    do_start(32'd4, 32'd1);
    exp_q.push_back(32'd128);
    for (int k = 0; k < 4; k++)
      drive_beat(fill(32'd2), (k == 2), (k == 2) ? 2'd2 : 2'd0);
    drive_idle();
    wait_done("t4");
    check("t4_err_count", {32'd0, err_count}, 64'd1);
    check("t4_last_count", {32'd0, last_count}, 64'd1);
    check("t4_beat_count", {32'd0, beat_count}, 64'd4);
    wait_drain("t4");

    // Large positive sum: wraps or saturates depending on build.
`ifdef MATRIX_ACC_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'hFFFF_FFE0;
`endif
    do_start(32'd2, 32'd1);
    exp_q.push_back(sat_exp);
    for (int k = 0; k < 2; k++) drive_beat(fill(32'h7FFF_FFFF), 1'b0, 2'd0);
    drive_idle();
    wait_done("t5");
    wait_drain("t5");

    // Reset in the middle of a group, then a clean run.
    do_start(32'd4, 32'd1);
    for (int k = 0; k < 3; k++) drive_beat(fill(32'd1), 1'b0, 2'd0);
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_beat_count", {32'd0, beat_count}, 64'd0);
    check("t6_rst_state", {62'd0, dbg_state}, 64'd0);
    check("t6_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_rst_overflow", {63'd0, overflow}, 64'd0);
    do_start(32'd4, 32'd1);
    exp_q.push_back(32'd64);
    for (int k = 0; k < 4; k++) drive_beat(fill(32'd1), 1'b0, 2'd0);
    drive_idle();
    wait_done("t6");
    check("t6_group_count", {32'd0, group_count}, 64'd1);
    wait_drain("t6");

    // Zero groups: start goes straight to DONE.
    do_start(32'd3, 32'd0);
    @(negedge clk);
    check("t7_zero_groups_done", {63'd0, done}, 64'd1);
    check("t7_zero_groups_busy", {63'd0, busy}, 64'd0);

    repeat (10) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/matrix_row_accumulator.md
# matrix_row_accumulator

Downstream consumer of the matrix read engine's AXI read-data channel. Sums every beat of 16 signed 32-bit lanes, closes a result after a programmed number of beats (one work group), and queues the 32-bit group result in an output FIFO for the compute/writeback stage. The read engine holds rready high, so this block never backpressures its input. Overload is reported through sticky status, not stalls.

## Interface
- LANES, 16, signed 32-bit lanes per beat; rdata width is LANES*32.
- FIFO_DEPTH, 16, output result FIFO entries (power of two).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches parameters and begins a run.
- beats_per_group  in  32  beats per group result; 0 is treated as 1.
- num_groups  in  32  group results to produce this run.
- rvalid  in  1  read-data beat valid (no ready returned).
- rdata  in  LANES*32  beat payload, lane i = rdata[32i+31:32i].
- rlast  in  1  burst-last marker; counted only.
- rresp  in  2  response code; nonzero counts as an error.
- out_valid  out  1  result available.
- out_data  out  32  group result.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at end of run.
- beat_count, group_count, last_count, err_count, drop_count  out  32 each  run counters.
- overflow  out  1  sticky: a result was dropped on a full FIFO.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start. Latch parameters. Clear the counters, accumulator, pipeline and overflow. The FIFO is not cleared.
- IDLE with num_groups==0: start goes to DONE directly.
- RUN: each rvalid beat enters the pipeline and increments beat_count. last_count increments on rvalid&rlast. err_count increments on rvalid&(rresp!=0); that beat is still summed.
- Pipeline stages:
  - S1: register the beat.
  - S2: 16->4 partial sums, 34-bit signed.
  - S3: 4->1 lane sum, 36-bit signed.
  - S4: add into a 64-bit signed accumulator.
- A per-beat group index travels with the data. The beat that completes beats_per_group pushes (acc + lane_sum) to the FIFO. The accumulator then restarts at 0, and group_count increments when the push is attempted.
- RUN -> DRAIN when the beat that completes group num_groups is accepted. Any further rvalid beats in DRAIN/DONE/IDLE are ignored and not counted.
- DRAIN -> DONE when the pipeline is empty (4 cycles). DONE pulses done and returns to IDLE.
- FIFO full on push: result dropped, drop_count+1, overflow set. A pop in the same cycle frees a slot, so the push is accepted.
- out_data is the FIFO head, truncated from 64 bits per Configuration.
- start while busy is ignored.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, done=0, overflow=0, all counters 0, state IDLE, FIFO empty.
- Parameters are sampled on the start cycle. busy=1 from the next cycle.
- Beat accepted in cycle N: its lane sum enters the accumulator at N+3. If it closes a group, the FIFO is written at N+4, and out_valid rises at N+5 when the FIFO was empty.
- The pipeline sustains one beat per cycle indefinitely, including back-to-back groups with beats_per_group=1.
- out_valid/out_data are registered. With out_valid=1, out_data is held until accepted.
- done pulses 5 cycles after the final beat; busy falls in the same cycle.
- Accumulator arithmetic wraps at 64 bits. Lane sums are sign-extended.

## Configuration
- MATRIX_ACC_SATURATE_EN defined: out_data clamps the 64-bit result to [-2^31, 2^31-1].
- MATRIX_ACC_SATURATE_EN undefined: out_data = result[31:0] (wrap).

## Test plan
- beats_per_group=4, num_groups=2, 8 consecutive beats, every lane = 1 -> two results of 64 each. First out_valid 5 cycles after beat 4. done 5 cycles after beat 8. beat_count=8, group_count=2.
- beats_per_group=0, num_groups=3, three beats with lane i = i -> three results of 120 each (0 treated as 1).
- out_ready=0, beats_per_group=1, num_groups=20, FIFO_DEPTH=16 -> 16 results held, drop_count=4, overflow=1. Then out_ready=1 drains exactly 16.
- One beat with rresp=2 and rlast=1 among 4 beats of lane value 2 -> result 128, err_count=1, last_count=1.
- Every lane = 0x7FFFFFFF, beats_per_group=2 -> wrapped 0xFFFFFFE0 without the macro, 0x7FFFFFFF with it.
- rst asserted mid-RUN after 3 beats -> all outputs at reset values next cycle. A new start with 4 beats of lane value 1 yields exactly one result of 64 (with beats_per_group=4, num_groups=1).
